// File: rtl/mst_read_arb_pkg.sv
// Shared definitions for the single-word bus-master read arbiter:
// state encoding, bus control bit positions and default sizing.
package tape_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int IN_MSTREAD_REQ = 0;
  localparam int IN_MST_TYPE    = 1;
  localparam int IN_DST_RDY_N   = 2;
  localparam int IN_WIDTH       = 5;

  localparam int OUT_CMD_ACK    = 0;
  localparam int OUT_SRC_RDY_N  = 3;
  localparam int OUT_WIDTH      = 6;

  localparam int DEF_MST_LENGTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1023;
  localparam int TMO_W              = 10;
  localparam int LEN_W              = 12;

  // Destination-ready is active-low, so it idles high everywhere except DATA.
  function automatic logic [IN_WIDTH-1:0] bus_inputs(input state_e st);
    logic [IN_WIDTH-1:0] v;
    v = '0;
    v[IN_DST_RDY_N] = 1'b1;
    case (st)
      ST_CMD: begin
        v[IN_MSTREAD_REQ] = 1'b1;
        v[IN_MST_TYPE]    = 1'b1;
      end
      ST_DATA: v[IN_DST_RDY_N] = 1'b0;
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mst_read_arb_if.sv
// Requester and bus-master signal bundle for mst_read_arb; the master
// modport is the arbiter's view, slave is the requesters/bus side.
interface mst_read_arb_if;
  import tape_bus_pkg::*;

  logic                 req0;
  logic                 req1;
  logic [31:0]          addr0;
  logic [31:0]          addr1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rd_valid0;
  logic                 rd_valid1;
  logic                 rd_err0;
  logic                 rd_err1;
  logic [31:0]          rd_data;
  logic [31:0]          ip2bus_mst_addr;
  logic [LEN_W-1:0]     ip2bus_mst_length;
  logic [31:0]          ip2bus_mstrd_d;
  logic [IN_WIDTH-1:0]  ip2bus_inputs;
  logic [OUT_WIDTH-1:0] ip2bus_otputs;

  modport master (
    input  req0, req1, addr0, addr1, ip2bus_mstrd_d, ip2bus_otputs,
    output gnt0, gnt1, rd_valid0, rd_valid1, rd_err0, rd_err1, rd_data,
           ip2bus_mst_addr, ip2bus_mst_length, ip2bus_inputs
  );

  modport slave (
    output req0, req1, addr0, addr1, ip2bus_mstrd_d, ip2bus_otputs,
    input  gnt0, gnt1, rd_valid0, rd_valid1, rd_err0, rd_err1, rd_data,
           ip2bus_mst_addr, ip2bus_mst_length, ip2bus_inputs
  );

endinterface

// File: rtl/mst_read_arb_rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to
// whichever requester was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  assign any    = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/mst_read_arb.sv
// Arbitrates two word-read requesters onto one bus-master read port and
// returns the captured word with a valid pulse, or an error pulse on timeout.
module mst_read_arb
  import tape_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MST_LENGTH     = DEF_MST_LENGTH
) (
  input logic            clk,
  input logic            reset,
  mst_read_arb_if.master bus
);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [31:0]        addr_q, addr_d;

  logic               winner;
  logic               any_req;
  logic               timed_out;
  logic               cmd_ack;
  logic               src_rdy_n;
  logic               unused_otputs;

  rr_arb2 u_rr_arb2 (
    .req    ({bus.req1, bus.req0}),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  assign cmd_ack       = bus.ip2bus_otputs[OUT_CMD_ACK];
  assign src_rdy_n     = bus.ip2bus_otputs[OUT_SRC_RDY_N];
  assign unused_otputs = ^{bus.ip2bus_otputs[5:4], bus.ip2bus_otputs[2:1]};
  assign timed_out     = (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      rd_data_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_data_q <= rd_data_d;
      addr_q    <= addr_d;
    end
  end

  // Timeout is checked before the handshake so it wins a same-cycle tie.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_data_d = rd_data_q;
    addr_d    = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          addr_d  = winner ? bus.addr1 : bus.addr0;
          tmo_d   = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (timed_out) begin
          state_d = ST_ERR;
        end else if (cmd_ack) begin
          tmo_d   = '0;
          state_d = ST_DATA;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (timed_out) begin
          state_d = ST_ERR;
        end else if (!src_rdy_n) begin
          rd_data_d = bus.ip2bus_mstrd_d;
          state_d   = ST_DONE;
        end else begin
          tmo_d     = tmo_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt0              = (state_q != ST_IDLE) && !owner_q;
  assign bus.gnt1              = (state_q != ST_IDLE) &&  owner_q;
  assign bus.rd_valid0         = (state_q == ST_DONE) && !owner_q;
  assign bus.rd_valid1         = (state_q == ST_DONE) &&  owner_q;
  assign bus.rd_err0           = (state_q == ST_ERR)  && !owner_q;
  assign bus.rd_err1           = (state_q == ST_ERR)  &&  owner_q;
  assign bus.rd_data           = rd_data_q;
  assign bus.ip2bus_mst_addr   = addr_q;
  assign bus.ip2bus_mst_length = LEN_W'(MST_LENGTH);
  assign bus.ip2bus_inputs     = bus_inputs(state_q);

endmodule

// File: doc/mst_read_arb.md
MST_READ_ARB -- requirements
Module: mst_read_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum wait in CMD or DATA before abort (10-bit counter).
REQ-002 SHALL have parameter MST_LENGTH, default 4, meaning the byte count driven on ip2bus_mst_length (single 32-bit word).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req0 / req1, input, 1 bit each: requester read request, level.
REQ-006 SHALL have port addr0 / addr1, input, 32 bits each: requester word address.
REQ-007 SHALL have port gnt0 / gnt1, output, 1 bit each: requester owns the bus, level.
REQ-008 SHALL have port rd_valid0 / rd_valid1, output, 1 bit each: one-cycle data-return pulse.
REQ-009 SHALL have port rd_err0 / rd_err1, output, 1 bit each: one-cycle timeout-abort pulse.
REQ-010 SHALL have port rd_data, output, 32 bits: captured bus word, shared, raw byte order.
REQ-011 SHALL have port ip2bus_mst_addr, output, 32 bits: latched address of the granted requester.
REQ-012 SHALL have port ip2bus_mst_length, output, 12 bits: constant MST_LENGTH.
REQ-013 SHALL have port ip2bus_mstrd_d, input, 32 bits: read data from the bus master.
REQ-014 SHALL have port ip2bus_inputs, output, 5 bits, mapped as:
- [0] mstread_req
- [1] mst_type
- [2] mstrd_dst_rdy_n (active-low)
- [4:3] tied 0
REQ-015 SHALL have port ip2bus_otputs, input, 6 bits, mapped as:
- [0] cmd_ack
- [3] mstrd_src_rdy_n (active-low)
- other bits ignored

Function
REQ-016 SHALL implement the states IDLE, CMD, DATA, DONE, ERR, one-hot or binary.
REQ-017 IDLE: if either req is sampled high, SHALL pick the winner, latch its address, set its gnt and go to CMD; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; a single request wins regardless of history.
REQ-019 CMD: SHALL drive ip2bus_inputs[0] and [1] high and [2] high; on cmd_ack go to DATA.
REQ-020 DATA: SHALL drive ip2bus_inputs[0] and [1] low and [2] low; when mstrd_src_rdy_n is low, SHALL capture ip2bus_mstrd_d into rd_data and go to DONE.
REQ-021 DONE: SHALL pulse rd_validN of the granted requester for one cycle, record it as last granted, clear gnt and go to IDLE.
REQ-022 In all states other than DATA, ip2bus_inputs[2] SHALL be high.
REQ-023 With a zero-wait bus, rd_validN SHALL be high in the 3rd cycle after req is first sampled (IDLE -> CMD -> DATA -> DONE).
REQ-024 Timeout counter SHALL clear on entry to CMD and on entry to DATA, and increment each cycle spent in those states.
REQ-025 When the timeout counter equals TIMEOUT_CYCLES, SHALL go to ERR, overriding any cmd_ack or src_rdy_n arriving in that same cycle.
REQ-026 ERR: SHALL pulse rd_errN of the granted requester for one cycle, record it as last granted, clear gnt, go to IDLE, and leave rd_data unchanged.
REQ-027 Requesters SHALL hold req and addr until rd_valid or rd_err; deasserting req after grant SHALL NOT abort the transaction, and the pulse is still issued.
REQ-028 Re-arbitration SHALL occur only in IDLE, giving at least one IDLE cycle between transactions.
REQ-029 gnt0 and gnt1 SHALL never be high together, and rd_valid/rd_err SHALL go only to the granted requester.

Reset
REQ-030 On reset, the block SHALL:
- go to IDLE
- clear gnt0/1, rd_valid0/1, rd_err0/1 and the timeout counter
- set rd_data and ip2bus_mst_addr to 0
- set ip2bus_inputs to 5'b00100
- set last-granted to requester 1, so requester 0 wins first
REQ-031 Reset asserted mid-transaction SHALL abandon it with no rd_valid or rd_err pulse; bus request lines SHALL be deasserted from the next cycle.
REQ-032 Reset SHALL take priority over every other state transition.

Structure
REQ-033 Shared package tape_bus_pkg SHALL hold:
- state encoding
- ip2bus_inputs and ip2bus_otputs bit indices
- MST_LENGTH and TIMEOUT_CYCLES defaults
REQ-034 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req[1:0], last; outputs winner, any).

Verification
REQ-035 After reset, req0=1 with addr0=32'h1f500000 and a zero-wait bus returning 32'hdeadbeef -> ip2bus_mst_addr=32'h1f500000, length=4, rd_valid0 in cycle 3, rd_data=32'hdeadbeef.
REQ-036 req0 and req1 both held high for 4 transactions -> grant order 0,1,0,1, with no overlapping gnt.
REQ-037 cmd_ack never asserted -> rd_err0 pulses exactly TIMEOUT_CYCLES+1 cycles after CMD entry, then IDLE with no rd_valid.
REQ-038 src_rdy_n held low 5 cycles after cmd_ack -> rd_valid1 once, with data taken from the first low cycle.
REQ-039 Reset asserted in DATA -> ip2bus_inputs=5'b00100 the next cycle, no pulses, then req1 alone is granted next.
REQ-040 req0 dropped during CMD -> transaction completes and rd_valid0 still pulses once.
